// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch / program-counter stage in front of the opcode decoder.
// Holds the PC and requests one instruction word at a time over a
// variable-latency request/valid handshake. It presents the held word, its
// OPCODE and FUNCTION fields to the decoder, and then waits for the execute
// stage to retire it. On retire, the decoder's redirect results select the
// next PC. Sequencing is FETCH -> ISSUE -> FETCH, so there is one bubble
// cycle between instructions. HALT parks the sequencer until RESET.
//
// Ports:
//   CLK          in   1        clock, rising edge
//   RESET        in   1        asynchronous, active-high reset
//   IMEM_REQ     out  1        fetch request, held until IMEM_VALID
//   IMEM_ADDR    out  PC_W     fetch address (= PC)
//   IMEM_RDATA   in   INSTR_W  fetched word, sampled when IMEM_VALID=1
//   IMEM_VALID   in   1        memory returns a word this cycle
//   INSTR        out  INSTR_W  held instruction word
//   OPCODE       out  4        INSTR[15:12]
//   FUNCTION     out  3        INSTR[2:0]
//   INSTR_VALID  out  1        INSTR/OPCODE/FUNCTION are valid
//   INSTR_ACK    in   1        execute retires the held instruction
//   BRANCH       in   1        conditional branch
//   ALU_COND     in   1        branch condition from the ALU
//   JUMP         in   1        absolute jump (j, jal)
//   JR           in   1        jump register
//   JR_TARGET    in   PC_W     register value for JR
//   HALT         in   1        halt
//   PC           out  PC_W     address of the held instruction
//   PC_PLUS1     out  PC_W     PC+1, also the JAL link value
//   HALTED       out  1        sequencer stopped
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INSTR_W  = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               IMEM_REQ,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    input  logic               IMEM_VALID,
    output logic [INSTR_W-1:0] INSTR,
    output logic [3:0]         OPCODE,
    output logic [2:0]         FUNCTION,
    output logic               INSTR_VALID,
    input  logic               INSTR_ACK,
    input  logic               BRANCH,
    input  logic               ALU_COND,
    input  logic               JUMP,
    input  logic               JR,
    input  logic [PC_W-1:0]    JR_TARGET,
    input  logic               HALT,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    PC_PLUS1,
    output logic               HALTED
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    branch_target;
    logic [PC_W-1:0]    jump_target;

    // All PC arithmetic wraps modulo 2^PC_W by truncation to PC_W bits.
    assign pc_plus1      = pc_q + PC_W'(1);
    // The branch offset is signed 8-bit and is relative to PC+1.
    assign branch_target = pc_plus1 + {{(PC_W-8){instr_q[7]}}, instr_q[7:0]};
    // An absolute jump replaces only the low 12 bits and keeps the current page.
    assign jump_target   = {pc_q[PC_W-1:12], instr_q[11:0]};

    // Next-state logic and next-PC selection.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        unique case (state_q)
            ST_FETCH: begin
                if (IMEM_VALID) begin
                    instr_d = IMEM_RDATA;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (INSTR_ACK) begin
                    valid_d = 1'b0;
                    // Priority: HALT > JR > JUMP > taken branch > sequential.
                    if (HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                        if (JR)                     pc_d = JR_TARGET;
                        else if (JUMP)              pc_d = jump_target;
                        else if (BRANCH && ALU_COND) pc_d = branch_target;
                        else                        pc_d = pc_plus1;
                    end
                end
            end

            ST_HALTED: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so that every
            // register samples the pre-edge values, whatever the statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // The reset state is FETCH. Gating with RESET keeps the request low while
    // reset is held, and drops it at once when reset arrives mid-fetch.
    assign IMEM_REQ    = (state_q == ST_FETCH) && !RESET;
    assign IMEM_ADDR   = pc_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[15:12];
    assign FUNCTION    = instr_q[2:0];
    assign INSTR_VALID = valid_q;
    assign PC          = pc_q;
    assign PC_PLUS1    = pc_plus1;
    assign HALTED      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_sequencer. Scenario tasks are called in sequence. Inputs
// are driven on the falling edge, and outputs are sampled there before the
// next drive. A behavioural next-PC model tracks the expected fetch address.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int          PC_W    = 16;
    localparam int          INSTR_W = 16;
    localparam logic [15:0] RST_PC  = 16'h0000;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               IMEM_REQ;
    logic [PC_W-1:0]    IMEM_ADDR;
    logic [INSTR_W-1:0] IMEM_RDATA;
    logic               IMEM_VALID;
    logic [INSTR_W-1:0] INSTR;
    logic [3:0]         OPCODE;
    logic [2:0]         FUNCTION;
    logic               INSTR_VALID;
    logic               INSTR_ACK;
    logic               BRANCH;
    logic               ALU_COND;
    logic               JUMP;
    logic               JR;
    logic [PC_W-1:0]    JR_TARGET;
    logic               HALT;
    logic [PC_W-1:0]    PC;
    logic [PC_W-1:0]    PC_PLUS1;
    logic               HALTED;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pc;

    always #5 CLK = ~CLK;

    fetch_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (RST_PC),
        .INSTR_W  (INSTR_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDATA  (IMEM_RDATA),
        .IMEM_VALID  (IMEM_VALID),
        .INSTR       (INSTR),
        .OPCODE      (OPCODE),
        .FUNCTION    (FUNCTION),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_ACK   (INSTR_ACK),
        .BRANCH      (BRANCH),
        .ALU_COND    (ALU_COND),
        .JUMP        (JUMP),
        .JR          (JR),
        .JR_TARGET   (JR_TARGET),
        .HALT        (HALT),
        .PC          (PC),
        .PC_PLUS1    (PC_PLUS1),
        .HALTED      (HALTED)
    );

    // ------------------------------------------------------------------ model
    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] word,
                                               input logic br, input logic cond, input logic jmp,
                                               input logic jr, input logic halt, input logic [15:0] jrt);
        int off;
        if (halt) return pc;
        if (jr) return jrt;
        if (jmp) return (pc & 16'hF000) | (word & 16'h0FFF);
        if (br && cond) begin
            off = int'(word[7:0]);
            if (off > 127) off = off - 256;
            return 16'(int'(pc) + 1 + off);
        end
        return 16'(int'(pc) + 1);
    endfunction

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic scramble_redirects();
        BRANCH    = 1'($urandom);
        ALU_COND  = 1'($urandom);
        JUMP      = 1'($urandom);
        JR        = 1'($urandom);
        HALT      = 1'($urandom);
        JR_TARGET = 16'($urandom);
    endtask

    // Called in FETCH. Withholds IMEM_VALID for lat cycles, then returns word.
    // stable reports whether REQ/ADDR stayed held and INSTR_VALID stayed low.
    task automatic fetch_word(input logic [15:0] word, input int lat, output logic stable);
        logic [15:0] addr0;
        addr0  = IMEM_ADDR;
        stable = (IMEM_REQ === 1'b1);
        for (int i = 0; i < lat; i++) begin
            IMEM_VALID = 1'b0;
            IMEM_RDATA = 16'($urandom);
            INSTR_ACK  = 1'($urandom);
            scramble_redirects();
            tick();
            if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== addr0 || INSTR_VALID !== 1'b0) stable = 1'b0;
        end
        IMEM_VALID = 1'b1;
        IMEM_RDATA = word;
        INSTR_ACK  = 1'($urandom);
        scramble_redirects();
        tick();
        IMEM_VALID = 1'b0;
        INSTR_ACK  = 1'b0;
    endtask

    // Called in ISSUE. Holds ACK off for ack_lat cycles, then retires with the
    // given redirect inputs. stable reports whether INSTR was held with no request.
    task automatic retire(input logic br, input logic cond, input logic jmp, input logic jr,
                          input logic halt, input logic [15:0] jrt, input int ack_lat,
                          output logic stable);
        logic [15:0] w0;
        w0     = INSTR;
        stable = (INSTR_VALID === 1'b1);
        for (int i = 0; i < ack_lat; i++) begin
            INSTR_ACK  = 1'b0;
            IMEM_VALID = 1'($urandom);
            IMEM_RDATA = 16'($urandom);
            scramble_redirects();
            tick();
            if (INSTR !== w0 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b1) stable = 1'b0;
        end
        INSTR_ACK  = 1'b1;
        BRANCH     = br;
        ALU_COND   = cond;
        JUMP       = jmp;
        JR         = jr;
        HALT       = halt;
        JR_TARGET  = jrt;
        IMEM_VALID = 1'($urandom);
        tick();
        INSTR_ACK  = 1'b0;
        IMEM_VALID = 1'b0;
        scramble_redirects();
    endtask

    // Moves the sequencer to target through a JR instruction.
    task automatic goto_pc(input logic [15:0] target);
        logic st;
        fetch_word(16'($urandom), 0, st);
        retire(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, target, 0, st);
        m_pc = target;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        RESET = 1'b1;
        IMEM_VALID = 1'b0; IMEM_RDATA = '0; INSTR_ACK = 1'b0;
        BRANCH = 1'b0; ALU_COND = 1'b0; JUMP = 1'b0; JR = 1'b0; HALT = 1'b0; JR_TARGET = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b expected 0 0 0", IMEM_REQ, INSTR_VALID, HALTED);
        end
        checks++;
        if (PC !== RST_PC || INSTR !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: pc=%h instr=%h expected pc=%h instr=0000", PC, INSTR, RST_PC);
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h expected 1 %h", IMEM_REQ, IMEM_ADDR, RST_PC);
        end
        m_pc = RST_PC;
    endtask

    task automatic test_sequential();
        logic [15:0] last_word;
        last_word = '0;
        IMEM_VALID = 1'b1; INSTR_ACK = 1'b1;
        BRANCH = 1'b0; ALU_COND = 1'b0; JUMP = 1'b0; JR = 1'b0; HALT = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i % 2 == 0) begin
                if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC + 16'(i / 2) || INSTR_VALID !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_fetch[%0d]: req=%b addr=%h valid=%b expected 1 %h 0",
                             i, IMEM_REQ, IMEM_ADDR, INSTR_VALID, RST_PC + 16'(i / 2));
                end
                last_word  = 16'($urandom);
                IMEM_RDATA = last_word;
            end else begin
                if (INSTR_VALID !== 1'b1 || IMEM_REQ !== 1'b0 || INSTR !== last_word || PC !== RST_PC + 16'(i / 2)) begin
                    errors++;
                    $display("FAIL seq_issue[%0d]: valid=%b req=%b instr=%h pc=%h expected 1 0 %h %h",
                             i, INSTR_VALID, IMEM_REQ, INSTR, PC, last_word, RST_PC + 16'(i / 2));
                end
                IMEM_RDATA = 16'($urandom);
            end
            tick();
        end
        IMEM_VALID = 1'b0; INSTR_ACK = 1'b0;
        m_pc = RST_PC + 16'd4;
    endtask

    task automatic test_branch();
        logic st;
        goto_pc(16'h0010);
        checks++;
        if (IMEM_ADDR !== 16'h0010) begin
            errors++;
            $display("FAIL jr_goto: addr=%h expected 0010", IMEM_ADDR);
        end
        fetch_word(16'h9005, 0, st);
        retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h0016) begin
            errors++;
            $display("FAIL branch_taken: addr=%h expected 0016", IMEM_ADDR);
        end
        goto_pc(16'h0010);
        fetch_word(16'h9005, 0, st);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h0011) begin
            errors++;
            $display("FAIL branch_not_taken: addr=%h expected 0011", IMEM_ADDR);
        end
        goto_pc(16'h0010);
        fetch_word(16'h90FE, 0, st);
        retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h000F) begin
            errors++;
            $display("FAIL branch_negative: addr=%h expected 000f", IMEM_ADDR);
        end
        m_pc = 16'h000F;
    endtask

    task automatic test_jal();
        logic st;
        goto_pc(16'h4050);
        fetch_word(16'hB123, 0, st);
        checks++;
        if (PC_PLUS1 !== 16'h4051) begin
            errors++;
            $display("FAIL jal_link: pc_plus1=%h expected 4051", PC_PLUS1);
        end
        checks++;
        if (OPCODE !== 4'hB || FUNCTION !== 3'h3) begin
            errors++;
            $display("FAIL jal_fields: opcode=%h function=%h expected b 3", OPCODE, FUNCTION);
        end
        retire(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom), 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h4123) begin
            errors++;
            $display("FAIL jal_target: addr=%h expected 4123", IMEM_ADDR);
        end
        m_pc = 16'h4123;
    endtask

    task automatic test_jr_priority();
        logic st;
        fetch_word(16'h9012, 0, st);
        retire(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h0200) begin
            errors++;
            $display("FAIL jr_priority: addr=%h expected 0200", IMEM_ADDR);
        end
        m_pc = 16'h0200;
    endtask

    task automatic test_mem_latency();
        logic st;
        logic [15:0] w;
        w = 16'($urandom);
        fetch_word(w, 3, st);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL mem_latency_hold: stable=%b expected 1", st);
        end
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR !== w || PC !== m_pc) begin
            errors++;
            $display("FAIL mem_latency_word: valid=%b instr=%h pc=%h expected 1 %h %h", INSTR_VALID, INSTR, PC, w, m_pc);
        end
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        m_pc = m_pc + 16'd1;
    endtask

    task automatic test_ack_hold();
        logic st;
        fetch_word(16'($urandom), 0, st);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4, st);
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold_stable: stable=%b expected 1", st);
        end
        m_pc = m_pc + 16'd1;
        checks++;
        if (IMEM_ADDR !== m_pc || IMEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold_next: addr=%h req=%b expected %h 1", IMEM_ADDR, IMEM_REQ, m_pc);
        end
    endtask

    task automatic test_wrap();
        logic st;
        goto_pc(16'hFFFF);
        fetch_word(16'h1234, 0, st);
        checks++;
        if (PC_PLUS1 !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_plus1: pc_plus1=%h expected 0000", PC_PLUS1);
        end
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_seq: addr=%h expected 0000", IMEM_ADDR);
        end
        goto_pc(16'hFFF0);
        fetch_word(16'h907F, 0, st);
        retire(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        checks++;
        if (IMEM_ADDR !== 16'h0070) begin
            errors++;
            $display("FAIL wrap_branch: addr=%h expected 0070", IMEM_ADDR);
        end
        m_pc = 16'h0070;
    endtask

    task automatic test_random();
        logic        st;
        logic [15:0] w, jrt;
        logic        br, cond, jmp, jr;
        for (int n = 0; n < 300; n++) begin
            w    = 16'($urandom);
            jrt  = 16'($urandom);
            br   = 1'($urandom);
            cond = 1'($urandom);
            jmp  = ($urandom_range(0, 3) == 0);
            jr   = ($urandom_range(0, 4) == 0);
            checks++;
            if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== m_pc) begin
                errors++;
                $display("FAIL rand_addr[%0d]: req=%b addr=%h expected 1 %h", n, IMEM_REQ, IMEM_ADDR, m_pc);
            end
            fetch_word(w, int'($urandom_range(0, 3)), st);
            checks++;
            if (st !== 1'b1 || INSTR_VALID !== 1'b1 || INSTR !== w) begin
                errors++;
                $display("FAIL rand_fetch[%0d]: stable=%b valid=%b instr=%h expected 1 1 %h", n, st, INSTR_VALID, INSTR, w);
            end
            checks++;
            if (OPCODE !== w[15:12] || FUNCTION !== w[2:0] || PC !== m_pc || PC_PLUS1 !== 16'(m_pc + 16'd1)) begin
                errors++;
                $display("FAIL rand_fields[%0d]: op=%h fn=%h pc=%h pc1=%h expected %h %h %h %h",
                         n, OPCODE, FUNCTION, PC, PC_PLUS1, w[15:12], w[2:0], m_pc, 16'(m_pc + 16'd1));
            end
            retire(br, cond, jmp, jr, 1'b0, jrt, int'($urandom_range(0, 2)), st);
            checks++;
            if (st !== 1'b1) begin
                errors++;
                $display("FAIL rand_issue_hold[%0d]: stable=%b expected 1", n, st);
            end
            m_pc = model_next(m_pc, w, br, cond, jmp, jr, 1'b0, jrt);
        end
        checks++;
        if (IMEM_ADDR !== m_pc) begin
            errors++;
            $display("FAIL rand_final: addr=%h expected %h", IMEM_ADDR, m_pc);
        end
    endtask

    task automatic test_halt();
        logic        st;
        logic        parked;
        logic [15:0] halt_pc;
        halt_pc = m_pc;
        fetch_word(16'hE000, 0, st);
        retire(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 16'($urandom), 0, st);
        checks++;
        if (HALTED !== 1'b1 || INSTR_VALID !== 1'b0 || PC !== halt_pc) begin
            errors++;
            $display("FAIL halt_enter: halted=%b valid=%b pc=%h expected 1 0 %h", HALTED, INSTR_VALID, PC, halt_pc);
        end
        parked = 1'b1;
        for (int i = 0; i < 20; i++) begin
            IMEM_VALID = 1'($urandom);
            INSTR_ACK  = 1'($urandom);
            scramble_redirects();
            tick();
            if (IMEM_REQ !== 1'b0 || HALTED !== 1'b1 || INSTR_VALID !== 1'b0 || PC !== halt_pc) parked = 1'b0;
        end
        checks++;
        if (parked !== 1'b1) begin
            errors++;
            $display("FAIL halt_parked: parked=%b expected 1", parked);
        end
        IMEM_VALID = 1'b0; INSTR_ACK = 1'b0;
        RESET = 1'b1;
        #1;
        checks++;
        if (HALTED !== 1'b0 || PC !== RST_PC) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h expected 0 %h", HALTED, PC, RST_PC);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        m_pc = RST_PC;
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RST_PC) begin
            errors++;
            $display("FAIL halt_resume: req=%b addr=%h expected 1 %h", IMEM_REQ, IMEM_ADDR, RST_PC);
        end
        fetch_word(16'($urandom), 1, st);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, st);
        m_pc = RST_PC + 16'd1;
        checks++;
        if (IMEM_ADDR !== m_pc) begin
            errors++;
            $display("FAIL halt_resume_seq: addr=%h expected %h", IMEM_ADDR, m_pc);
        end
    endtask

    task automatic test_async_reset();
        logic st;
        goto_pc(16'h0123);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || PC !== RST_PC) begin
            errors++;
            $display("FAIL async_reset_fetch: req=%b valid=%b pc=%h expected 0 0 %h", IMEM_REQ, INSTR_VALID, PC, RST_PC);
        end
        // A return arriving while reset is held must not be captured.
        IMEM_VALID = 1'b1;
        IMEM_RDATA = 16'hA5A5;
        @(negedge CLK);
        RESET = 1'b0;
        IMEM_VALID = 1'b0;
        #1;
        checks++;
        if (INSTR_VALID !== 1'b0 || INSTR !== 16'h0000 || IMEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL reset_late_valid: valid=%b instr=%h req=%b expected 0 0000 1", INSTR_VALID, INSTR, IMEM_REQ);
        end
        m_pc = RST_PC;
        fetch_word(16'h5A5A, 0, st);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (INSTR_VALID !== 1'b0 || INSTR !== 16'h0000 || IMEM_REQ !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_issue: valid=%b instr=%h req=%b expected 0 0000 0", INSTR_VALID, INSTR, IMEM_REQ);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Watchdog: the scenario sequence is fixed length, so this only trips on a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_jr_priority();
        test_mem_latency();
        test_ack_hold();
        test_wrap();
        test_random();
        test_halt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and program-counter stage directly upstream of the opcode decoder.
- Holds the PC and requests instruction words from instruction memory over a variable-latency handshake.
- Presents OPCODE/FUNCTION to the decoder.
- Consumes the decoder's BRANCH/JUMP/JR/HALT results plus the ALU condition to select the next PC; JAL link value is produced here.

Parameters:
- PC_W, 16, program counter and instruction-address width.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_W, 16, instruction word width; fixed fields below assume 16.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IMEM_REQ  out  1  fetch request, held until IMEM_VALID.
- IMEM_ADDR  out  PC_W  fetch address (= PC).
- IMEM_RDATA  in  INSTR_W  fetched word, sampled when IMEM_VALID=1.
- IMEM_VALID  in  1  memory returns word this cycle.
- INSTR  out  INSTR_W  held instruction word.
- OPCODE  out  4  INSTR[15:12], to decoder.
- FUNCTION  out  3  INSTR[2:0], to decoder.
- INSTR_VALID  out  1  INSTR/OPCODE/FUNCTION are valid.
- INSTR_ACK  in  1  execute stage retires held instruction; redirect inputs are sampled this cycle.
- BRANCH  in  1  decoder: conditional branch.
- ALU_COND  in  1  ALU branch condition (zero/equal result).
- JUMP  in  1  decoder: absolute jump (j, jal).
- JR  in  1  decoder: jump register.
- JR_TARGET  in  PC_W  register value for JR.
- HALT  in  1  decoder: halt.
- PC  out  PC_W  address of held instruction.
- PC_PLUS1  out  PC_W  PC+1; JAL link value.
- HALTED  out  1  sequencer stopped.

Behaviour:
- Reset, asynchronous: PC=RESET_PC, state=FETCH, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, HALTED=0. First request is issued in the first cycle after RESET deasserts.
- States: FETCH, ISSUE, HALTED.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC.
  - On IMEM_VALID: INSTR<=IMEM_RDATA, INSTR_VALID<=1, go to ISSUE.
  - A fetch returning in the same cycle as the request is legal; minimum latency is 1 cycle from request to INSTR_VALID.
- ISSUE:
  - IMEM_REQ=0. INSTR held stable until INSTR_ACK.
  - On INSTR_ACK, next PC has priority HALT > JR > JUMP > taken branch > sequential:
    - HALT: PC unchanged, INSTR_VALID<=0, go to HALTED.
    - JR: PC<=JR_TARGET.
    - JUMP: PC<={PC[PC_W-1:12], INSTR[11:0]}.
    - BRANCH & ALU_COND: PC<=PC+1+sign_extend(INSTR[7:0]).
    - Otherwise: PC<=PC+1.
  - In every non-halt case: INSTR_VALID<=0 and go to FETCH. This gives one bubble cycle between instructions.
  - BRANCH with ALU_COND=0 is sequential.
- HALTED: terminal. IMEM_REQ=0, INSTR_VALID=0, HALTED=1. Only RESET exits.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. PC=all-ones +1 wraps to 0. Branch offset range is -128..+127 relative to PC+1.
- INSTR_ACK while INSTR_VALID=0 is ignored. Redirect inputs are don't-care except in the ACK cycle.
- IMEM_VALID outside FETCH is ignored.
- PC_PLUS1 is combinational PC+1.
- RESET mid-fetch or mid-issue: abandon immediately and return to reset values. A late IMEM_VALID after reset is ignored unless the new FETCH request is pending.

Test Plan:
- Reset, IMEM_VALID=1 every request cycle, ACK immediately with no redirects:
  - IMEM_ADDR sequence is 0,1,2,3.
  - INSTR_VALID pulses every 2 cycles.
- Word 0x9005 at PC=0x0010, BRANCH=1, ALU_COND=1, ACK -> next IMEM_ADDR=0x0016.
- Same word with ALU_COND=0 -> next address 0x0011.
- Word 0x90FE at PC=0x0010, taken -> next address 0x000F (negative offset).
- Word 0xB123 (jal) at PC=0x4050, JUMP=1:
  - PC_PLUS1=0x4051 during ISSUE.
  - Next IMEM_ADDR=0x4123.
- JR=1, JUMP=1, JR_TARGET=0x0200 simultaneously -> next address 0x0200 (JR wins).
- IMEM_VALID delayed 3 cycles -> IMEM_REQ and IMEM_ADDR held stable, INSTR_VALID stays 0.
- ACK withheld 4 cycles -> INSTR stays stable, no new request.
- Word 0xE000 with HALT=1, ACK:
  - HALTED=1, IMEM_REQ stays 0 for 20 cycles.
  - RESET pulse -> PC=RESET_PC and fetching resumes.
- PC=0xFFFF sequential ACK -> next IMEM_ADDR=0x0000.
- RESET asserted mid-FETCH -> IMEM_REQ=0 and INSTR_VALID=0 asynchronously, before the next clock edge.
